// File: rtl/operand_pair_scheduler_if.sv
// Producer load port and datapath issue port of the operand pair scheduler.
// The slave modport is the scheduler; the master side is the producer/datapath.
interface operand_pair_scheduler_if #(
  parameter int ITEM_WIDTH = 8
);
  logic                  batch_req_o;
  logic                  wr_en_i;
  logic [ITEM_WIDTH-1:0] wr_a_i;
  logic [ITEM_WIDTH-1:0] wr_b_i;
  logic                  batch_ack_i;
  logic [ITEM_WIDTH-1:0] A_s;
  logic [ITEM_WIDTH-1:0] B_s;
  logic                  issue_o;

  modport master (
    input  batch_req_o, A_s, B_s, issue_o,
    output wr_en_i, wr_a_i, wr_b_i, batch_ack_i
  );

  modport slave (
    output batch_req_o, A_s, B_s, issue_o,
    input  wr_en_i, wr_a_i, wr_b_i, batch_ack_i
  );
endinterface

// File: rtl/operand_pair_scheduler.sv
// Buffers one batch of operand pairs from a producer, then replays them to the
// datapath one pair per cycle, repeating for BATCH_NUM batches per run.
//
// state | meaning
// IDLE  | waiting for start_i after reset
// LOAD  | batch_req_o high, producer filling the pair buffer
// ISSUE | replaying latched pairs onto A_s/B_s, one per cycle
// DONE  | BATCH_NUM batches issued, done_o held until next start_i
module operand_pair_scheduler #(
  parameter int NUM_PAIRS  = 16,
  parameter int BATCH_NUM  = 2000,
  parameter int ITEM_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  operand_pair_scheduler_if.slave  bus,
  output logic [15:0]              batch_cnt_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int              CW         = $clog2(NUM_PAIRS + 1);
  localparam int              AW         = $clog2(NUM_PAIRS);
  localparam logic [CW-1:0]   FULL       = CW'(NUM_PAIRS);
  localparam logic [CW-1:0]   ONE        = CW'(1);
  localparam logic [15:0]     LAST_BATCH = 16'(BATCH_NUM - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;

  state_t                    state;
  logic [CW-1:0]             wr_ptr;
  logic [CW-1:0]             rd_ptr;
  logic [CW-1:0]             pair_cnt;
  logic [2*ITEM_WIDTH-1:0]   mem [NUM_PAIRS];
  logic [2*ITEM_WIDTH-1:0]   rd_pair;
  logic                      wr_ok;

  assign wr_ok   = (state == LOAD) && bus.wr_en_i && (wr_ptr != FULL);
  assign rd_pair = mem[rd_ptr[AW-1:0]];

  // Buffer contents survive reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= {bus.wr_a_i, bus.wr_b_i};
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      pair_cnt        <= '0;
      batch_cnt_o     <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      bus.batch_req_o <= 1'b0;
      bus.issue_o     <= 1'b0;
      bus.A_s         <= '0;
      bus.B_s         <= '0;
    end else begin
      bus.issue_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            batch_cnt_o     <= '0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            wr_ptr          <= '0;
            busy_o          <= 1'b1;
            bus.batch_req_o <= 1'b1;
            state           <= LOAD;
          end
          if (bus.wr_en_i || bus.batch_ack_i) err_o <= 1'b1;
        end
        LOAD: begin
          if (wr_ok) wr_ptr <= wr_ptr + ONE;
          if (bus.wr_en_i && !wr_ok) err_o <= 1'b1;
          // A write landing with the ack belongs to this batch.
          if (bus.batch_ack_i) begin
            if (wr_ok || (wr_ptr != '0)) begin
              pair_cnt        <= wr_ok ? wr_ptr + ONE : wr_ptr;
              rd_ptr          <= '0;
              bus.batch_req_o <= 1'b0;
              state           <= ISSUE;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.wr_en_i || bus.batch_ack_i) err_o <= 1'b1;
          bus.issue_o <= 1'b1;
          bus.A_s     <= rd_pair[2*ITEM_WIDTH-1:ITEM_WIDTH];
          bus.B_s     <= rd_pair[ITEM_WIDTH-1:0];
          rd_ptr      <= rd_ptr + ONE;
          if (rd_ptr + ONE == pair_cnt) begin
            batch_cnt_o <= batch_cnt_o + 16'd1;
            wr_ptr      <= '0;
            if (batch_cnt_o == LAST_BATCH) begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= DONE;
            end else begin
              bus.batch_req_o <= 1'b1;
              state           <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_pair_scheduler.sv
// Directed bench for operand_pair_scheduler with NUM_PAIRS=4, BATCH_NUM=2:
// a cycle table for two full batches, then hand sequences for the corner cases.
module tb_operand_pair_scheduler;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] batch_cnt_o;
  logic        busy_o, done_o, err_o;

  operand_pair_scheduler_if #(.ITEM_WIDTH(8)) bus ();

  operand_pair_scheduler #(.NUM_PAIRS(4), .BATCH_NUM(2), .ITEM_WIDTH(8)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .bus         (bus.slave),
    .batch_cnt_o (batch_cnt_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int start, wr, a, b, ack;
    int issue, ea, eb, req, busy, done, err, cnt;
  } vec_t;

  vec_t vecs[21];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit s, input bit w, input int a, input int b, input bit k);
    @(negedge clk_i);
    start_i         = s;
    bus.wr_en_i     = w;
    bus.wr_a_i      = 8'(a);
    bus.wr_b_i      = 8'(b);
    bus.batch_ack_i = k;
    @(posedge clk_i);
    #1;
  endtask

  task automatic collect(input int ncyc, input bit pulse_start,
                         output int n, output int fa, output int la, output int lb);
    n = 0; fa = -1; la = -1; lb = -1;
    for (int i = 0; i < ncyc; i++) begin
      step(pulse_start && (i == 0), 1'b0, 0, 0, 1'b0);
      if (bus.issue_o) begin
        if (n == 0) fa = int'(bus.A_s);
        n++;
        la = int'(bus.A_s);
        lb = int'(bus.B_s);
      end
    end
  endtask

  function automatic logic [36:0] outs();
    return {bus.issue_o, bus.A_s, bus.B_s, bus.batch_req_o, busy_o, done_o, err_o, batch_cnt_o};
  endfunction

  initial begin
    logic [36:0] exp_p;
    int n, fa, la, lb;

    //              st wr  a   b ack iss ea eb req busy done err cnt
    vecs[0]  = '{1, 0,  0,  0, 0,  0,  0,  0, 1, 1, 0, 0, 0};
    vecs[1]  = '{0, 1,  1,  2, 0,  0,  0,  0, 1, 1, 0, 0, 0};
    vecs[2]  = '{0, 1,  3,  4, 0,  0,  0,  0, 1, 1, 0, 0, 0};
    vecs[3]  = '{0, 1,  5,  6, 0,  0,  0,  0, 1, 1, 0, 0, 0};
    vecs[4]  = '{0, 1,  7,  8, 0,  0,  0,  0, 1, 1, 0, 0, 0};
    vecs[5]  = '{0, 0,  0,  0, 1,  0,  0,  0, 0, 1, 0, 0, 0};
    vecs[6]  = '{0, 0,  0,  0, 0,  1,  1,  2, 0, 1, 0, 0, 0};
    vecs[7]  = '{0, 0,  0,  0, 0,  1,  3,  4, 0, 1, 0, 0, 0};
    vecs[8]  = '{0, 0,  0,  0, 0,  1,  5,  6, 0, 1, 0, 0, 0};
    vecs[9]  = '{0, 0,  0,  0, 0,  1,  7,  8, 1, 1, 0, 0, 1};
    vecs[10] = '{0, 0,  0,  0, 0,  0,  7,  8, 1, 1, 0, 0, 1};
    vecs[11] = '{0, 1, 11, 12, 0,  0,  7,  8, 1, 1, 0, 0, 1};
    vecs[12] = '{0, 1, 13, 14, 0,  0,  7,  8, 1, 1, 0, 0, 1};
    vecs[13] = '{0, 1, 15, 16, 0,  0,  7,  8, 1, 1, 0, 0, 1};
    vecs[14] = '{0, 1, 17, 18, 0,  0,  7,  8, 1, 1, 0, 0, 1};
    vecs[15] = '{0, 0,  0,  0, 1,  0,  7,  8, 0, 1, 0, 0, 1};
    vecs[16] = '{0, 0,  0,  0, 0,  1, 11, 12, 0, 1, 0, 0, 1};
    vecs[17] = '{0, 0,  0,  0, 0,  1, 13, 14, 0, 1, 0, 0, 1};
    vecs[18] = '{0, 0,  0,  0, 0,  1, 15, 16, 0, 1, 0, 0, 1};
    vecs[19] = '{0, 0,  0,  0, 0,  1, 17, 18, 0, 0, 1, 0, 2};
    vecs[20] = '{0, 0,  0,  0, 0,  0, 17, 18, 0, 0, 1, 0, 2};

    bus.wr_en_i = 1'b0; bus.wr_a_i = '0; bus.wr_b_i = '0; bus.batch_ack_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outputs", 64'(outs()), 64'd0);
    @(negedge clk_i);
    reset_i = 1'b1;

    // Two full batches of four pairs, cycle by cycle.
    for (int i = 0; i < 21; i++) begin
      step(vecs[i].start[0], vecs[i].wr[0], vecs[i].a, vecs[i].b, vecs[i].ack[0]);
      exp_p = {vecs[i].issue[0], vecs[i].ea[7:0], vecs[i].eb[7:0], vecs[i].req[0],
               vecs[i].busy[0], vecs[i].done[0], vecs[i].err[0], vecs[i].cnt[15:0]};
      chk($sformatf("table_vec%0d", i), 64'(outs()), 64'(exp_p));
    end

    // Short batch of two pairs; operands hold the last pair afterwards.
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 9, 9, 1'b0);
    step(1'b0, 1'b1, 10, 10, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    collect(8, 1'b0, n, fa, la, lb);
    chk("short_issue_count", n, 2);
    chk("short_first_a", fa, 9);
    chk("short_hold_ab", {la[7:0], lb[7:0]}, {8'd10, 8'd10});
    chk("short_batch_cnt", batch_cnt_o, 1);
    chk("short_err", err_o, 0);

    // Empty ack, then overflow of a 4-deep buffer.
    step(1'b0, 1'b0, 0, 0, 1'b1);
    chk("empty_ack_state", {err_o, busy_o, bus.batch_req_o, bus.issue_o}, 4'b1110);
    chk("empty_ack_cnt", batch_cnt_o, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 20 + i, 120 + i, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    collect(8, 1'b0, n, fa, la, lb);
    chk("ovf_issue_count", n, 4);
    chk("ovf_first_a", fa, 20);
    chk("ovf_last_ab", {la[7:0], lb[7:0]}, {8'd23, 8'd123});
    chk("ovf_err", err_o, 1);
    chk("ovf_done", {done_o, busy_o, batch_cnt_o}, {1'b1, 1'b0, 16'd2});

    // Restart from DONE; third write shares its cycle with the ack.
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("restart_clear", {err_o, done_o, busy_o, batch_cnt_o}, {1'b0, 1'b0, 1'b1, 16'd0});
    step(1'b0, 1'b1, 1, 1, 1'b0);
    step(1'b0, 1'b1, 2, 2, 1'b0);
    step(1'b0, 1'b1, 3, 3, 1'b1);
    collect(8, 1'b0, n, fa, la, lb);
    chk("wr_ack_issue_count", n, 3);
    chk("wr_ack_last_ab", {la[7:0], lb[7:0]}, {8'd3, 8'd3});
    chk("wr_ack_cnt", batch_cnt_o, 1);

    // start_i during ISSUE is ignored.
    step(1'b0, 1'b1, 4, 4, 1'b0);
    step(1'b0, 1'b1, 5, 5, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    collect(8, 1'b1, n, fa, la, lb);
    chk("start_in_issue_count", n, 2);
    chk("start_in_issue_last", {la[7:0], lb[7:0]}, {8'd5, 8'd5});
    chk("start_in_issue_flags", {err_o, done_o, busy_o, batch_cnt_o}, {1'b0, 1'b1, 1'b0, 16'd2});

    // Reset during the second issue cycle abandons the batch.
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 6, 6, 1'b0);
    step(1'b0, 1'b1, 7, 7, 1'b0);
    step(1'b0, 1'b1, 8, 8, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    chk("pre_reset_issue", {bus.issue_o, bus.A_s}, {1'b1, 8'd6});
    #2 reset_i = 1'b0;
    #1;
    chk("mid_issue_reset", 64'(outs()), 64'd0);
    @(negedge clk_i);
    reset_i = 1'b1;
    collect(6, 1'b0, n, fa, la, lb);
    chk("post_reset_no_issue", {n[3:0], busy_o, bus.batch_req_o}, 6'd0);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("post_reset_restart", {busy_o, bus.batch_req_o, bus.issue_o}, 3'b110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_pair_scheduler.md
OPERAND_PAIR_SCHEDULER -- requirements
Module: operand_pair_scheduler

Interface
REQ-001 SHALL have parameter NUM_PAIRS, default 16, giving the maximum operand pairs per batch (buffer depth); legal range 2..1024.
REQ-002 SHALL have parameter BATCH_NUM, default 2000, giving the number of batches to issue per run; legal range 1..65535.
REQ-003 SHALL have parameter ITEM_WIDTH, default 8, giving the operand width.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start_i, input, 1 bit: one-cycle pulse that starts a run.
REQ-007 SHALL have port batch_req_o, output, 1 bit: high while the scheduler accepts a new batch from the producer.
REQ-008 SHALL have ports wr_en_i (input, 1 bit), wr_a_i (input, ITEM_WIDTH) and wr_b_i (input, ITEM_WIDTH): the pair write port.
REQ-009 SHALL have port batch_ack_i, input, 1 bit: one-cycle pulse meaning the producer has finished loading the batch.
REQ-010 SHALL have ports A_s and B_s, outputs, ITEM_WIDTH each, registered: operands to the datapath.
REQ-011 SHALL have port issue_o, output, 1 bit: high in the cycle A_s/B_s carry a newly issued pair.
REQ-012 SHALL have port batch_cnt_o, output, 16 bits: number of completed batches.
REQ-013 SHALL have ports busy_o, done_o and err_o, outputs, 1 bit each: run active, run complete (sticky), protocol error (sticky).

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, ISSUE and DONE, all state registered.
REQ-015 IDLE: a start_i pulse SHALL clear batch_cnt_o, done_o, err_o and the write pointer, then enter LOAD.
REQ-016 LOAD SHALL assert batch_req_o; each cycle with wr_en_i=1 SHALL store {wr_a_i, wr_b_i} at the write pointer and increment it.
REQ-017 LOAD: wr_en_i when the write pointer equals NUM_PAIRS SHALL discard the data, hold the pointer and set err_o.
REQ-018 LOAD: batch_ack_i with the write pointer greater than 0 SHALL latch the pair count, clear the read pointer and enter ISSUE the next cycle; batch_req_o SHALL deassert in that same next cycle.
REQ-019 LOAD: batch_ack_i with the write pointer equal to 0 SHALL set err_o, stay in LOAD and leave batch_cnt_o unchanged.
REQ-020 LOAD: wr_en_i and batch_ack_i in the same cycle SHALL store the pair first; the stored pair counts toward the batch.
REQ-021 ISSUE SHALL issue one pair per cycle in write order: A_s/B_s update and issue_o=1 for exactly the latched count of consecutive cycles.
REQ-022 The first pair SHALL appear on A_s/B_s one cycle after ISSUE is entered.
REQ-023 After the last pair is issued, batch_cnt_o SHALL increment by 1 and the write pointer SHALL clear.
REQ-024 After the last pair, the FSM SHALL enter DONE if the new batch_cnt_o equals BATCH_NUM, otherwise LOAD.
REQ-025 A_s and B_s SHALL hold their last value whenever issue_o=0.
REQ-026 wr_en_i or batch_ack_i outside LOAD SHALL be ignored and SHALL set err_o.
REQ-027 start_i outside IDLE and DONE SHALL be ignored, without setting err_o.
REQ-028 DONE SHALL set done_o; start_i in DONE SHALL behave as in IDLE.
REQ-029 busy_o SHALL be 1 in LOAD and ISSUE, and 0 otherwise.
REQ-030 All counters SHALL be sized so they never wrap within the legal parameter ranges.

Reset
REQ-031 reset_i low SHALL immediately force IDLE, A_s=0, B_s=0, issue_o=0, batch_req_o=0, batch_cnt_o=0, busy_o=0, done_o=0, err_o=0, and clear both pointers; buffer contents need not be cleared.
REQ-032 Reset asserted mid-LOAD or mid-ISSUE SHALL abandon the batch; after release, no pair SHALL issue until a new start_i pulse.

Verification
REQ-033 NUM_PAIRS=4, BATCH_NUM=2; start, write (1,2)(3,4)(5,6)(7,8), ack -> A_s/B_s show 1/2, 3/4, 5/6, 7/8 on 4 consecutive issue_o cycles; batch_cnt_o=1; batch_req_o re-asserts; repeat the batch -> done_o=1, busy_o=0, batch_cnt_o=2.
REQ-034 Write 2 pairs (9,9)(10,10), then ack -> exactly 2 issue cycles; A_s/B_s then hold 10/10.
REQ-035 Write 5 pairs with NUM_PAIRS=4 -> err_o=1 and only the first 4 pairs issue; ack with 0 pairs -> err_o=1, FSM stays in LOAD, batch_cnt_o unchanged.
REQ-036 wr_en_i and batch_ack_i asserted in the same cycle as the 3rd write -> 3 pairs issue.
REQ-037 Pull reset_i low during the 2nd ISSUE cycle -> all outputs 0 immediately; after release, no issue_o until start_i.
REQ-038 Pulse start_i during ISSUE -> ignored, err_o stays 0, and the batch completes normally.
